mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified `memory` instance between instruction fetch (IF) and the data-memory stage (DM) of the RV32I core. Each cycle it grants at most one requester and drives the memory port from that requester. It returns registered read data and valid/error flags to the granted side one cycle later. DM has default priority; a starvation counter bounds IF wait time.

## Interface
- `AWIDTH`, 32, address width
- `DWIDTH`, 32, data width; `BYTES = DWIDTH/8`
- `MAX_WAIT`, 4, consecutive denied IF cycles before IF is forced to win (≥1)

Ports:
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `if_req_i`  in  1  fetch read request
- `if_addr_i`  in  AWIDTH  fetch address
- `if_gnt_o`  out  1  fetch granted this cycle
- `if_rdata_o`  out  DWIDTH  fetch read data (registered)
- `if_rvld_o`  out  1  fetch response valid, 1-cycle pulse
- `if_err_o`  out  1  fetch response was out-of-range
- `dm_req_i`  in  1  data request
- `dm_we_i`  in  1  1 = store, 0 = load
- `dm_addr_i`  in  AWIDTH  data address
- `dm_wdata_i`  in  DWIDTH  store data
- `dm_wstrb_i`  in  BYTES  store byte strobes
- `dm_gnt_o`  out  1  data granted this cycle
- `dm_rdata_o`  out  DWIDTH  load data (registered)
- `dm_rvld_o`  out  1  load response valid, 1-cycle pulse
- `dm_err_o`  out  1  load/store was out-of-range
- `mem_addr_o`, `mem_data_o`, `mem_strb_o`, `mem_rd_o`, `mem_wr_o`  out  to memory `addr_i`, `data_i`, `write_strb_i`, `read_en_i`, `write_en_i`
- `mem_data_i`  in  DWIDTH  memory `data_o` (combinational read)
- `mem_vld_i`  in  1  memory `data_vld_o`

## Operation
- Request rule: a requester holds `*_req_i` and payload stable until it samples its `*_gnt_o` high. Grant consumes the request.
- Arbitration is combinational, evaluated every cycle:
  - Only one requester: it wins.
  - Both requesting: DM wins, unless `wait_cnt == MAX_WAIT`, in which case IF wins.
- Memory drive:
  - IF granted: `mem_rd_o=1`, `mem_wr_o=0`, addr from IF.
  - DM granted: `mem_rd_o=~dm_we_i`, `mem_wr_o=dm_we_i`, addr/data/strb from DM.
  - No grant: all mem strobes 0, addr/data/strb 0.
- Response registers, loaded at the grant edge:
  - `owner_q ∈ {ARB_NONE, ARB_IF, ARB_DM}`.
  - `rdata_q = mem_data_i`; `err_q = ~mem_vld_i`.
  - `is_store_q` set for DM stores.
- Response cycle outputs:
  - `if_rvld_o = (owner_q==ARB_IF)`.
  - `dm_rvld_o = (owner_q==ARB_DM) & ~is_store_q`.
  - `*_err_o` asserts alongside owner, including for stores.
  - `*_rdata_o = rdata_q` when owner matches, else 0.
- `wait_cnt` (width `$clog2(MAX_WAIT+1)`):
  - +1 when `if_req_i & ~if_gnt_o`, saturating at `MAX_WAIT`.
  - Cleared on IF grant or when `if_req_i=0`.
- Out-of-range (`mem_vld_i=0`): response still issued, with `rdata=0` and `err=1`. A store is dropped by memory, and the arbiter reports `dm_err_o` only.

## Timing
- Grant: same cycle as the request, combinational. Read data: next cycle (latency 1).
- Store commits at the grant edge.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating sides are legal. A new grant in cycle N+1 coexists with the response for cycle N.
- Reset values:
  - `owner_q=ARB_NONE`, `rdata_q=0`, `err_q=0`, `is_store_q=0`, `wait_cnt=0`.
  - All `*_rvld_o`, `*_err_o`, `*_rdata_o` = 0.
- While `rst=1`: `*_gnt_o=0` and `mem_rd_o=mem_wr_o=0`, regardless of requests.
- Reset mid-operation: a pending response is discarded (no rvld after reset deasserts). The requester must re-issue.
- Requests dropping low without a grant are legal and leave no state except clearing `wait_cnt`.

## Structure
- Shared package (`constants.svh`):
  - `typedef enum logic [1:0] {ARB_NONE, ARB_IF, ARB_DM} arb_owner_e`.
  - `ARB_MAX_WAIT_DEFAULT = 4`.
- Single module, no sub-module. The starvation counter and response registers are inline `always_ff` blocks with async reset. Grant logic is one `always_comb`.

## Test plan
- Memory base `0x0100_0000`; preload `base+0=0xDEADBEEF`, `base+4=0x11223344`.
- IF only, addr `base+0` → `if_gnt_o=1` same cycle; next cycle `if_rvld_o=1`, `if_rdata_o=0xDEADBEEF`, `if_err_o=0`.
- Both request; IF `base+0`, DM load `base+4` → DM granted first, IF next cycle. Responses: `dm_rdata_o=0x11223344` at N+1, `if_rdata_o=0xDEADBEEF` at N+2.
- DM store `base+8`, data `0x00FF0000`, strb `4'b0100`, over `0x11223344` → `dm_gnt_o=1`, no `dm_rvld_o`. A following IF read of `base+8` returns `0x11FF3344`.
- Starvation, `MAX_WAIT=4`: DM requests every cycle, IF held high → IF denied 4 cycles, granted on the 5th. `wait_cnt` then returns to 0.
- Out-of-range DM load `base-0x10` → next cycle `dm_rvld_o=1`, `dm_rdata_o=0`, `dm_err_o=1`.
- Reset asserted the cycle after an IF grant → `if_rvld_o` never pulses, all outputs 0. A request re-issued after reset completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_DM   = 2'd2
    } arb_owner_e;

    localparam int ARB_MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage.
// DM has priority; a saturating wait counter forces IF through after MAX_WAIT denials.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int MAX_WAIT = ARB_MAX_WAIT_DEFAULT,
    localparam int BYTES   = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    output logic              if_rvld_o,
    output logic              if_err_o,

    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [AWIDTH-1:0] dm_addr_i,
    input  logic [DWIDTH-1:0] dm_wdata_i,
    input  logic [BYTES-1:0]  dm_wstrb_i,
    output logic              dm_gnt_o,
    output logic [DWIDTH-1:0] dm_rdata_o,
    output logic              dm_rvld_o,
    output logic              dm_err_o,

    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [BYTES-1:0]  mem_strb_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    input  logic              mem_vld_i
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [WW-1:0]     wait_cnt;
    arb_owner_e        owner_q;
    logic [DWIDTH-1:0] rdata_q;
    logic              err_q;
    logic              is_store_q;

    // Grants are gated by rst so nothing reaches memory while held in reset.
    always_comb begin
        if_gnt_o   = 1'b0;
        dm_gnt_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_strb_o = '0;
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        if (!rst) begin
            if (if_req_i && dm_req_i) begin
                if (wait_cnt == WAIT_MAX) if_gnt_o = 1'b1;
                else                      dm_gnt_o = 1'b1;
            end else begin
                if_gnt_o = if_req_i;
                dm_gnt_o = dm_req_i;
            end
        end
        if (if_gnt_o) begin
            mem_rd_o   = 1'b1;
            mem_addr_o = if_addr_i;
        end else if (dm_gnt_o) begin
            mem_rd_o   = ~dm_we_i;
            mem_wr_o   = dm_we_i;
            mem_addr_o = dm_addr_i;
            mem_data_o = dm_wdata_i;
            mem_strb_o = dm_wstrb_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!if_req_i || if_gnt_o) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Out-of-range accesses still produce a response, with zeroed data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= ARB_NONE;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            is_store_q <= 1'b0;
        end else if (if_gnt_o) begin
            owner_q    <= ARB_IF;
            rdata_q    <= mem_vld_i ? mem_data_i : '0;
            err_q      <= ~mem_vld_i;
            is_store_q <= 1'b0;
        end else if (dm_gnt_o) begin
            owner_q    <= ARB_DM;
            rdata_q    <= (mem_vld_i && !dm_we_i) ? mem_data_i : '0;
            err_q      <= ~mem_vld_i;
            is_store_q <= dm_we_i;
        end else begin
            owner_q    <= ARB_NONE;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            is_store_q <= 1'b0;
        end
    end

    assign if_rvld_o  = (owner_q == ARB_IF);
    assign if_err_o   = (owner_q == ARB_IF) & err_q;
    assign if_rdata_o = (owner_q == ARB_IF) ? rdata_q : '0;

    assign dm_rvld_o  = (owner_q == ARB_DM) & ~is_store_q;
    assign dm_err_o   = (owner_q == ARB_DM) & err_q;
    assign dm_rdata_o = (owner_q == ARB_DM) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory model plus a per-cycle response scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BY = DW / 8;
    localparam int NW = 64;
    localparam logic [31:0] BASE = 32'h0100_0000;

    typedef struct {
        logic        if_v;
        logic [31:0] if_d;
        logic        if_e;
        logic        dm_v;
        logic [31:0] dm_d;
        logic        dm_e;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_rvld;
    logic          if_err;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [BY-1:0] dm_wstrb;
    logic          dm_gnt;
    logic [DW-1:0] dm_rdata;
    logic          dm_rvld;
    logic          dm_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic [BY-1:0] mem_strb;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdat;
    logic          mem_vld;

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];
    resp_t       exp_q   [$];
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rdata_o(if_rdata), .if_rvld_o(if_rvld), .if_err_o(if_err),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata), .dm_wstrb_i(dm_wstrb), .dm_gnt_o(dm_gnt),
        .dm_rdata_o(dm_rdata), .dm_rvld_o(dm_rvld), .dm_err_o(dm_err),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdat), .mem_strb_o(mem_strb),
        .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
        .mem_data_i(mem_rdat), .mem_vld_i(mem_vld)
    );

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(NW * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Environment memory: combinational read; out-of-range returns garbage with vld low.
    assign mem_vld  = in_rng(mem_addr) && (mem_rd || mem_wr);
    assign mem_rdat = in_rng(mem_addr) ? mem[widx(mem_addr)] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_wr && in_rng(mem_addr)) begin
            for (int b = 0; b < BY; b++)
                if (mem_strb[b]) mem[widx(mem_addr)][8*b +: 8] <= mem_wdat[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_resp();
        resp_t r;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        r = exp_q.pop_front();
        chk("if_rvld",  {31'd0, if_rvld}, {31'd0, r.if_v});
        chk("if_rdata", if_rdata,         r.if_d);
        chk("if_err",   {31'd0, if_err},  {31'd0, r.if_e});
        chk("dm_rvld",  {31'd0, dm_rvld}, {31'd0, r.dm_v});
        chk("dm_rdata", dm_rdata,         r.dm_d);
        chk("dm_err",   {31'd0, dm_err},  {31'd0, r.dm_e});
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds);
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd; dm_wstrb = ds;
    endtask

    // One cycle: check last cycle's response, drive a request, check grants, queue the expected response.
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds,
                        input logic eig, input logic edg);
        resp_t r;
        @(negedge clk);
        check_resp();
        drive(ir, ia, dr, dw, da, dd, ds);
        #1;
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
        chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, edg});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, edg & dw});
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, eig | (edg & ~dw)});
        r = '{default: '0};
        if (eig) begin
            r.if_v = 1'b1;
            r.if_e = ~in_rng(ia);
            r.if_d = in_rng(ia) ? ref_mem[widx(ia)] : 32'h0;
        end else if (edg) begin
            r.dm_e = ~in_rng(da);
            if (!dw) begin
                r.dm_v = 1'b1;
                r.dm_d = in_rng(da) ? ref_mem[widx(da)] : 32'h0;
            end else if (in_rng(da)) begin
                for (int b = 0; b < 4; b++)
                    if (ds[b]) ref_mem[widx(da)][8*b +: 8] = dd[8*b +: 8];
            end
        end
        exp_q.push_back(r);
    endtask

    task automatic idle(input logic eig, input logic edg);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, eig, edg);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_if_gnt"},  {31'd0, if_gnt},  32'd0);
        chk({tag, "_dm_gnt"},  {31'd0, dm_gnt},  32'd0);
        chk({tag, "_mem_rd"},  {31'd0, mem_rd},  32'd0);
        chk({tag, "_mem_wr"},  {31'd0, mem_wr},  32'd0);
        chk({tag, "_if_rvld"}, {31'd0, if_rvld}, 32'd0);
        chk({tag, "_dm_rvld"}, {31'd0, dm_rvld}, 32'd0);
        chk({tag, "_if_err"},  {31'd0, if_err},  32'd0);
        chk({tag, "_dm_err"},  {31'd0, dm_err},  32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem[0] = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;
        mem[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;
        mem[2] = 32'h1122_3344; ref_mem[2] = 32'h1122_3344;

        // Reset: requests are ignored and all outputs sit at zero.
        rst = 1'b1;
        drive(1'b1, BASE, 1'b1, 1'b0, BASE + 4, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp_q.push_back('{default: '0});

        // IF only.
        step(1'b1, BASE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // Both request: DM first, then IF.
        step(1'b1, BASE, 1'b1, 1'b0, BASE + 4, 32'h0, 4'h0, 1'b0, 1'b1);
        step(1'b1, BASE, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // Byte store then fetch of the same word.
        step(1'b0, 32'h0, 1'b1, 1'b1, BASE + 8, 32'h00FF_0000, 4'b0100, 1'b0, 1'b1);
        step(1'b1, BASE + 8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        chk("store_ref_word", ref_mem[2], 32'h11FF_3344);

        // Starvation: DM streams loads, IF held; IF wins on the 5th cycle.
        for (int i = 0; i < 4; i++)
            step(1'b1, BASE + 12, 1'b1, 1'b0, BASE + 32'(16 + 4*i), 32'h0, 4'h0, 1'b0, 1'b1);
        step(1'b1, BASE + 12, 1'b1, 1'b0, BASE + 32, 32'h0, 4'h0, 1'b1, 1'b0);
        // Counter cleared: a fresh IF request loses to DM again.
        step(1'b1, BASE + 4, 1'b1, 1'b0, BASE + 32, 32'h0, 4'h0, 1'b0, 1'b1);
        step(1'b1, BASE + 4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);

        // Request dropped without grant, then alternating back-to-back grants.
        step(1'b1, BASE, 1'b1, 1'b0, BASE + 4, 32'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, BASE + 40, 32'h0, 4'h0, 1'b0, 1'b1);
        step(1'b1, BASE + 44, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);

        // Out-of-range load, store and fetch.
        step(1'b0, 32'h0, 1'b1, 1'b0, BASE - 32'h10, 32'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, BASE - 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1);
        step(1'b1, BASE - 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);

        // Reset right after an IF grant: the response is discarded.
        step(1'b1, BASE + 4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        @(posedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        drive(1'b1, BASE, 1'b1, 1'b1, BASE, 32'h0, 4'hF);
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check_quiet("post_reset");
        exp_q.push_back('{default: '0});
        step(1'b1, BASE + 4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        @(negedge clk);
        check_resp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
